// File: rtl/alu_cu_pkg.sv
// Shared encodings for the registered RV32I/M ALU control decoder:
// opcode/funct constants, ALU select codes, FSM states and the decode bundle.
package alu_cu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_AND    = 5'd0;
  localparam logic [4:0] ALU_OR     = 5'd1;
  localparam logic [4:0] ALU_XOR    = 5'd2;
  localparam logic [4:0] ALU_ADD    = 5'd3;
  localparam logic [4:0] ALU_SUB    = 5'd4;
  localparam logic [4:0] ALU_SLT    = 5'd5;
  localparam logic [4:0] ALU_SLTU   = 5'd6;
  localparam logic [4:0] ALU_SLL    = 5'd7;
  localparam logic [4:0] ALU_SRL    = 5'd8;
  localparam logic [4:0] ALU_SRA    = 5'd9;
  localparam logic [4:0] ALU_ADDR   = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd11;
  localparam logic [4:0] ALU_MULH   = 5'd12;
  localparam logic [4:0] ALU_MULHSU = 5'd13;
  localparam logic [4:0] ALU_MULHU  = 5'd14;
  localparam logic [4:0] ALU_DIV    = 5'd15;
  localparam logic [4:0] ALU_DIVU   = 5'd16;
  localparam logic [4:0] ALU_REM    = 5'd17;
  localparam logic [4:0] ALU_REMU   = 5'd18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_VALID
  } state_e;

  typedef struct packed {
    logic [4:0] alusel;
    logic       cin;
    logic       branch;
    logic       m_op;
    logic       illegal;
    logic       is_div;
    logic       is_mul;
  } dec_t;

  // Base-ISA operation selected by funct3 alone (funct7 = 0000000 flavour).
  function automatic logic [4:0] base_alusel(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_cu_dec.sv
// Combinational RV32I/M instruction decoder producing ALU select, carry-in,
// branch, M-extension and illegal-encoding flags.
module alu_cu_dec
  import alu_cu_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] instruction,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instruction[6:0];
  assign funct3        = instruction[14:12];
  assign funct7        = instruction[31:25];
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  always_comb begin
    dec = '0;
    case (opcode)
      OP_REG: begin
        if (funct7 == F7_BASE) begin
          dec.alusel = base_alusel(funct3);
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          dec.alusel = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          dec.alusel = ALU_SRA;
        end else if (funct7 == F7_MULDIV && ENABLE_M) begin
          // funct3[2] splits the M group into multiply (0) and divide (1)
          dec.alusel = ALU_MUL + {2'b00, funct3};
          dec.m_op   = 1'b1;
          dec.is_div = funct3[2];
          dec.is_mul = !funct3[2];
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_IMM: begin
        if ((funct3 == F3_SLL && funct7 != F7_BASE) ||
            (funct3 == F3_SR && funct7 != F7_BASE && funct7 != F7_ALT)) begin
          dec.illegal = 1'b1;
        end else if (funct3 == F3_SR && funct7 == F7_ALT) begin
          dec.alusel = ALU_SRA;
        end else begin
          dec.alusel = base_alusel(funct3);
        end
      end
      OP_LOAD, OP_STORE: dec.alusel = ALU_ADDR;
      OP_BRANCH: begin
        dec.alusel = ALU_SUB;
        dec.branch = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: ;
      default: dec.illegal = 1'b1;
    endcase
    dec.cin = (dec.alusel == ALU_SUB) || (dec.alusel == ALU_SLT) ||
              (dec.alusel == ALU_SLTU);
  end

endmodule

// File: rtl/alu_cu_seq.sv
// Handshaked, registered ALU control decoder with fixed multi-cycle occupancy
// for RV32M multiply/divide and a pipeline flush.
module alu_cu_seq
  import alu_cu_pkg::*;
#(
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_LAT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alusel,
  output logic        cin,
  output logic        branch,
  output logic        m_op,
  output logic        illegal,
  output logic        busy
);

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic [4:0] alusel_q, alusel_d;
  logic       cin_q, cin_d;
  logic       branch_q, branch_d;
  logic       m_op_q, m_op_d;
  logic       illegal_q, illegal_d;
  logic       accept;
  dec_t       dec;

  alu_cu_dec #(.ENABLE_M(ENABLE_M)) u_dec (
    .instruction (instruction),
    .dec         (dec)
  );

  assign in_ready = !rst && !flush &&
                    (state_q == ST_IDLE || (state_q == ST_VALID && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    alusel_d    = alusel_q;
    cin_d       = cin_q;
    branch_d    = branch_q;
    m_op_d      = m_op_q;
    illegal_d   = illegal_q;
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      alusel_d    = '0;
      cin_d       = 1'b0;
      branch_d    = 1'b0;
      m_op_d      = 1'b0;
      illegal_d   = 1'b0;
    end else if (accept) begin
      // Accept covers both IDLE and the VALID handshake-with-next-instruction case
      alusel_d  = dec.alusel;
      cin_d     = dec.cin;
      branch_d  = dec.branch;
      m_op_d    = dec.m_op;
      illegal_d = dec.illegal;
      if (dec.is_mul && MUL_LAT > 1) begin
        state_d     = ST_WAIT;
        cnt_d       = MUL_CNT;
        busy_d      = 1'b1;
        out_valid_d = 1'b0;
      end else if (dec.is_div && DIV_LAT > 1) begin
        state_d     = ST_WAIT;
        cnt_d       = DIV_CNT;
        busy_d      = 1'b1;
        out_valid_d = 1'b0;
      end else begin
        state_d     = ST_VALID;
        cnt_d       = '0;
        busy_d      = 1'b0;
        out_valid_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q <= 6'd1) begin
            state_d     = ST_VALID;
            cnt_d       = '0;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        ST_VALID: begin
          if (out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      alusel_q    <= '0;
      cin_q       <= 1'b0;
      branch_q    <= 1'b0;
      m_op_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      alusel_q    <= alusel_d;
      cin_q       <= cin_d;
      branch_q    <= branch_d;
      m_op_q      <= m_op_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign alusel    = alusel_q;
  assign cin       = cin_q;
  assign branch    = branch_q;
  assign m_op      = m_op_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_cu_seq.sv
// Self-checking bench for alu_cu_seq: directed scenarios plus randomized
// instructions checked against a mnemonic-level decode/latency model.
module tb_alu_cu_seq;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0, in_valid2 = 1'b0;
  logic        out_ready = 1'b0, out_ready2 = 1'b0;
  logic [31:0] instruction = '0, instruction2 = '0;
  logic        in_ready, out_valid, cin, branch, m_op, illegal, busy;
  logic        in_ready2, out_valid2, cin2, branch2, m_op2, illegal2, busy2;
  logic [4:0]  alusel, alusel2;
  logic [8:0]  fields, fields2;

  int checks = 0;
  int errors = 0;

  assign fields  = {alusel, cin, branch, m_op, illegal};
  assign fields2 = {alusel2, cin2, branch2, m_op2, illegal2};

  always #5 clk = ~clk;

  alu_cu_seq #(.ENABLE_M(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .alusel(alusel), .cin(cin), .branch(branch), .m_op(m_op), .illegal(illegal),
    .busy(busy)
  );

  alu_cu_seq #(.ENABLE_M(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid2), .in_ready(in_ready2),
    .instruction(instruction2), .out_valid(out_valid2), .out_ready(out_ready2),
    .alusel(alusel2), .cin(cin2), .branch(branch2), .m_op(m_op2), .illegal(illegal2),
    .busy(busy2)
  );

  // Reference decode: returns {alusel, cin, branch, m_op, illegal} and latency.
  function automatic logic [8:0] ref_dec(input logic [31:0] ins, input bit en_m,
                                         output int lat);
    int base_tab [8] = '{3, 7, 5, 6, 2, 8, 1, 0};  // ADD SLL SLT SLTU XOR SRL OR AND
    int sel = 0;
    bit c, b = 0, m = 0, ill = 0;
    int op = int'(ins[6:0]);
    int f3 = int'(ins[14:12]);
    int f7 = int'(ins[31:25]);
    lat = 1;
    case (op)
      'h33: begin
        if (f7 == 0) sel = base_tab[f3];
        else if (f7 == 'h20 && f3 == 0) sel = 4;
        else if (f7 == 'h20 && f3 == 5) sel = 9;
        else if (f7 == 1 && en_m) begin
          sel = 11 + f3;
          m = 1;
          lat = (f3 < 4) ? MUL_LAT : DIV_LAT;
        end else ill = 1;
      end
      'h13: begin
        if (f3 == 1 && f7 != 0) ill = 1;
        else if (f3 == 5 && f7 == 'h20) sel = 9;
        else if (f3 == 5 && f7 != 0) ill = 1;
        else sel = base_tab[f3];
      end
      'h03, 'h23: sel = 10;
      'h63: begin sel = 4; b = 1; end
      'h37, 'h17, 'h6f, 'h67: sel = 0;
      default: ill = 1;
    endcase
    c = (sel == 4 || sel == 5 || sel == 6);
    return {sel[4:0], c, b, m, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = ops[k];
    else if (k == 9) w[6:0] = 7'h33;
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  // Present one instruction at a negedge, let it be taken at the next posedge.
  task automatic accept_one(input bit use2, input logic [31:0] ins, output logic rdy);
    @(negedge clk);
    if (use2) begin instruction2 = ins; in_valid2 = 1'b1; end
    else begin instruction = ins; in_valid = 1'b1; end
    #1 rdy = use2 ? in_ready2 : in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_valid2 = 1'b0;
  endtask

  // Cycles from accept until out_valid (-1 on timeout), plus busy cycles seen.
  task automatic wait_out(input bit use2, output int lat, output int bc);
    lat = 0;
    bc = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (use2 ? out_valid2 : out_valid) break;
      if (use2 ? busy2 : busy) bc++;
      if (lat >= 100) begin lat = -1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    instruction = 32'h40208033;
    out_ready = 1'b1;
    out_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
    checks++;
    if ({out_valid, busy, fields} !== 11'h0) begin
      errors++; $display("FAIL rst_outputs got %0h exp 0", {out_valid, busy, fields});
    end
    checks++;
    if ({out_valid2, busy2, fields2} !== 11'h0) begin
      errors++; $display("FAIL rst_outputs_nm got %0h exp 0", {out_valid2, busy2, fields2});
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_sub();
    logic rdy;
    int lat, bc;
    accept_one(1'b0, 32'h40208033, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL sub_ready got %0b exp 1", rdy); end
    wait_out(1'b0, lat, bc);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL sub_latency got %0d exp 1", lat); end
    checks++;
    if (fields !== {5'd4, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_fields got %0h exp %0h", fields, {5'd4, 4'b1000});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_handshake got %0b exp 0", out_valid); end
  endtask

  task automatic test_muldiv();
    logic rdy;
    int lat, bc;
    accept_one(1'b0, 32'h022081B3, rdy);
    wait_out(1'b0, lat, bc);
    checks++;
    if (lat != 2 || bc != 1) begin
      errors++; $display("FAIL mul_timing got lat %0d busy %0d exp lat 2 busy 1", lat, bc);
    end
    checks++;
    if (fields !== {5'd11, 4'b0010}) begin
      errors++; $display("FAIL mul_fields got %0h exp %0h", fields, {5'd11, 4'b0010});
    end
    accept_one(1'b0, 32'h0220D1B3, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL divu_ready got %0b exp 1", rdy); end
    wait_out(1'b0, lat, bc);
    checks++;
    if (lat != 8 || bc != 7) begin
      errors++; $display("FAIL divu_timing got lat %0d busy %0d exp lat 8 busy 7", lat, bc);
    end
    checks++;
    if (fields !== {5'd16, 4'b0010}) begin
      errors++; $display("FAIL divu_fields got %0h exp %0h", fields, {5'd16, 4'b0010});
    end
  endtask

  task automatic test_illegal();
    logic rdy;
    int lat, bc;
    accept_one(1'b1, 32'h022081B3, rdy);
    wait_out(1'b1, lat, bc);
    checks++;
    if (lat != 1 || fields2 !== {5'd0, 4'b0001}) begin
      errors++; $display("FAIL nom_mul got lat %0d fields %0h exp lat 1 fields 1", lat, fields2);
    end
    accept_one(1'b0, 32'h0000007F, rdy);
    wait_out(1'b0, lat, bc);
    checks++;
    if (lat != 1 || fields !== {5'd0, 4'b0001}) begin
      errors++; $display("FAIL op7f got lat %0d fields %0h exp lat 1 fields 1", lat, fields);
    end
  endtask

  task automatic test_backpressure();
    logic rdy;
    int lat, bc;
    @(negedge clk);
    out_ready = 1'b0;
    accept_one(1'b0, 32'h00208063, rdy);
    wait_out(1'b0, lat, bc);
    instruction = 32'h00108093;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({out_valid, in_ready, fields} !== {2'b10, 5'd4, 4'b1100}) begin
        errors++; $display("FAIL beq_hold cyc %0d got %0h exp %0h", i,
                           {out_valid, in_ready, fields}, {2'b10, 5'd4, 4'b1100});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %0b exp 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, fields} !== {1'b1, 5'd3, 4'b0000}) begin
      errors++; $display("FAIL queued_addi got %0h exp %0h", {out_valid, fields}, {1'b1, 9'h030});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_handshake got %0b exp 0", out_valid); end
  endtask

  task automatic test_flush(input bit use_rst);
    logic rdy;
    int seen = 0;
    out_ready = 1'b1;
    accept_one(1'b0, 32'h0220C1B3, rdy);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL kill%0d_busy got %0b exp 1", use_rst, busy); end
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    instruction = 32'h002081B3;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL kill%0d_ready got %0b exp 0", use_rst, in_ready); end
    @(posedge clk);
    #1 flush = 1'b0;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, fields} !== 11'h0) begin
      errors++; $display("FAIL kill%0d_clear got %0h exp 0", use_rst, {out_valid, busy, fields});
    end
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL kill%0d_no_output got %0d exp 0", use_rst, seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4] = '{32'h002081B3, 32'h0FF0C093, 32'h4050D093, 32'h0000A083};
    logic [4:0]  exp [4] = '{5'd3, 5'd2, 5'd9, 5'd10};
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instruction = ins[i];
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready %0d got %0b exp 1", i, in_ready); end
      @(negedge clk);
      checks++;
      if ({out_valid, alusel} !== {1'b1, exp[i]}) begin
        errors++; $display("FAIL b2b_out %0d got v%0b sel %0d exp v1 sel %0d", i, out_valid, alusel, exp[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [8:0]  exp, got;
    logic        rdy;
    int elat, lat, bc, k;
    bit u;
    for (int n = 0; n < 160; n++) begin
      u = (n % 4 == 3);
      @(negedge clk);
      out_ready = 1'b0;
      out_ready2 = 1'b0;
      ins = rand_instr();
      exp = ref_dec(ins, !u, elat);
      accept_one(u, ins, rdy);
      checks++;
      if (rdy !== 1'b1) begin errors++; $display("FAIL rnd_ready %0d got %0b exp 1", n, rdy); end
      wait_out(u, lat, bc);
      got = u ? fields2 : fields;
      checks++;
      if (lat != elat || bc != elat - 1) begin
        errors++; $display("FAIL rnd_lat %0d ins %08h got lat %0d busy %0d exp lat %0d", n, ins, lat, bc, elat);
      end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rnd_fields %0d ins %08h got %0h exp %0h", n, ins, got, exp); end
      k = $urandom_range(0, 2);
      repeat (k) begin
        @(negedge clk);
        checks++;
        if ({(u ? out_valid2 : out_valid), (u ? fields2 : fields)} !== {1'b1, exp}) begin
          errors++; $display("FAIL rnd_hold %0d got %0h exp %0h", n,
                             {(u ? out_valid2 : out_valid), (u ? fields2 : fields)}, {1'b1, exp});
        end
      end
      out_ready = 1'b1;
      out_ready2 = 1'b1;
      @(negedge clk);
      checks++;
      if ((u ? out_valid2 : out_valid) !== 1'b0) begin
        errors++; $display("FAIL rnd_handshake %0d got 1 exp 0", n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_muldiv();
    test_illegal();
    test_backpressure();
    test_flush(1'b0);
    test_flush(1'b1);
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
